// File: rtl/bullet_pool_ctrl.sv
// rtl/bullet_pool_ctrl.sv - four shared bullet slots: P1/P2 fire arbitration, muzzle spawn, tick movement, retire
module bullet_pool_ctrl #(
  parameter int X_MAX       = 160,
  parameter int Y_MAX       = 120,
  parameter int TANK_SIZE   = 8,
  parameter int BULLET_SIZE = 2,
  parameter int SPEED       = 2,
  parameter int COOLDOWN    = 16,
  parameter int MAX_PER_PLR = 2
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       tick,
  input  logic       p1_fire,
  input  logic       p2_fire,
  input  logic [7:0] p1_x,
  input  logic [7:0] p1_y,
  input  logic [7:0] p2_x,
  input  logic [7:0] p2_y,
  input  logic [1:0] p1_dir,
  input  logic [1:0] p2_dir,
  input  logic       p1_alive,
  input  logic       p2_alive,
  input  logic [3:0] bullet_destroy,
  output logic [3:0] bullet_active,
  output logic [7:0] bullet_x0,
  output logic [7:0] bullet_x1,
  output logic [7:0] bullet_x2,
  output logic [7:0] bullet_x3,
  output logic [7:0] bullet_y0,
  output logic [7:0] bullet_y1,
  output logic [7:0] bullet_y2,
  output logic [7:0] bullet_y3,
  output logic [3:0] bullet_owner,
  output logic       p1_fire_ack,
  output logic       p2_fire_ack
);

  localparam int CDW = $clog2(COOLDOWN + 1);
  localparam logic signed [9:0] L_XLIM = 10'(X_MAX - BULLET_SIZE);
  localparam logic signed [9:0] L_YLIM = 10'(Y_MAX - BULLET_SIZE);
  localparam logic signed [9:0] L_OFS  = 10'((TANK_SIZE - BULLET_SIZE) / 2);
  localparam logic signed [9:0] L_TS   = 10'(TANK_SIZE);
  localparam logic signed [9:0] L_BS   = 10'(BULLET_SIZE);
  localparam logic signed [9:0] L_SP   = 10'(SPEED);
  localparam logic [2:0]        L_MAXP = 3'(MAX_PER_PLR);

  logic [3:0]     r_active;
  logic [7:0]     r_x [4];
  logic [7:0]     r_y [4];
  logic [3:0]     r_owner;
  logic [1:0]     r_dir [4];
  logic [CDW-1:0] r_cd1;
  logic [CDW-1:0] r_cd2;
  logic           r_rr;
  logic           r_ack1;
  logic           r_ack2;

  function automatic logic signed [9:0] ext(input logic [7:0] v);
    return $signed({2'b00, v});
  endfunction

  function automatic logic in_field(input logic signed [9:0] px, input logic signed [9:0] py);
    return (px >= 10'sd0) && (px <= L_XLIM) && (py >= 10'sd0) && (py <= L_YLIM);
  endfunction

  // Muzzle position: bullet centred on the tank edge it faces, packed {x, y}.
  function automatic logic [19:0] spawn_pos(input logic [7:0] tx, input logic [7:0] ty,
                                            input logic [1:0] dir);
    logic signed [9:0] sx;
    logic signed [9:0] sy;
    sx = ext(tx) + L_OFS;
    sy = ext(ty) + L_OFS;
    case (dir)
      2'd0:    sy = ext(ty) - L_BS;
      2'd1:    sx = ext(tx) + L_TS;
      2'd2:    sy = ext(ty) + L_TS;
      default: sx = ext(tx) - L_BS;
    endcase
    return {sx, sy};
  endfunction

  logic [19:0]       w_sp1;
  logic [19:0]       w_sp2;
  logic              w_in1;
  logic              w_in2;
  logic [2:0]        w_cnt1;
  logic [2:0]        w_cnt2;
  logic [2:0]        w_nfree;
  logic [1:0]        w_f0;
  logic [1:0]        w_f1;
  logic              w_e1;
  logic              w_e2;
  logic              w_g1;
  logic              w_g2;
  logic [1:0]        w_s1;
  logic [1:0]        w_s2;
  logic              w_rr_nxt;
  logic signed [9:0] w_nx [4];
  logic signed [9:0] w_ny [4];
  logic [3:0]        w_mv_ok;

  assign w_sp1 = spawn_pos(p1_x, p1_y, p1_dir);
  assign w_sp2 = spawn_pos(p2_x, p2_y, p2_dir);
  assign w_in1 = in_field($signed(w_sp1[19:10]), $signed(w_sp1[9:0]));
  assign w_in2 = in_field($signed(w_sp2[19:10]), $signed(w_sp2[9:0]));

  // Scanning high to low leaves the lowest free index in w_f0 and the next one in w_f1.
  always_comb begin
    w_cnt1  = '0;
    w_cnt2  = '0;
    w_nfree = '0;
    w_f0    = '0;
    w_f1    = '0;
    for (int i = 3; i >= 0; i--) begin
      if (r_active[i]) begin
        if (r_owner[i]) w_cnt2 = w_cnt2 + 3'd1;
        else            w_cnt1 = w_cnt1 + 3'd1;
      end else begin
        w_f1    = w_f0;
        w_f0    = 2'(i);
        w_nfree = w_nfree + 3'd1;
      end
    end
  end

  assign w_e1 = p1_fire && p1_alive && (r_cd1 == '0) && (w_cnt1 < L_MAXP) && w_in1 && (w_nfree != 3'd0);
  assign w_e2 = p2_fire && p2_alive && (r_cd2 == '0) && (w_cnt2 < L_MAXP) && w_in2 && (w_nfree != 3'd0);

  always_comb begin
    w_g1     = 1'b0;
    w_g2     = 1'b0;
    w_s1     = w_f0;
    w_s2     = w_f0;
    w_rr_nxt = r_rr;
    if (w_e1 && w_e2) begin
      w_rr_nxt = ~r_rr;
      if (w_nfree >= 3'd2) begin
        w_g1 = 1'b1;
        w_g2 = 1'b1;
        if (r_rr) w_s1 = w_f1;
        else      w_s2 = w_f1;
      end else if (r_rr) begin
        w_g2 = 1'b1;
      end else begin
        w_g1 = 1'b1;
      end
    end else if (w_e1) begin
      w_g1 = 1'b1;
    end else if (w_e2) begin
      w_g2 = 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_nx[i] = ext(r_x[i]);
      w_ny[i] = ext(r_y[i]);
      case (r_dir[i])
        2'd0:    w_ny[i] = ext(r_y[i]) - L_SP;
        2'd1:    w_nx[i] = ext(r_x[i]) + L_SP;
        2'd2:    w_ny[i] = ext(r_y[i]) + L_SP;
        default: w_nx[i] = ext(r_x[i]) - L_SP;
      endcase
      w_mv_ok[i] = in_field(w_nx[i], w_ny[i]);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_active <= '0;
      r_owner  <= '0;
      r_cd1    <= '0;
      r_cd2    <= '0;
      r_rr     <= 1'b0;
      r_ack1   <= 1'b0;
      r_ack2   <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        r_x[i]   <= '0;
        r_y[i]   <= '0;
        r_dir[i] <= '0;
      end
    end else begin
      r_ack1 <= w_g1;
      r_ack2 <= w_g2;
      r_rr   <= w_rr_nxt;
      if (w_g1)                      r_cd1 <= CDW'(COOLDOWN);
      else if (tick && r_cd1 != '0) r_cd1 <= r_cd1 - CDW'(1);
      if (w_g2)                      r_cd2 <= CDW'(COOLDOWN);
      else if (tick && r_cd2 != '0) r_cd2 <= r_cd2 - CDW'(1);
      // Destroy wins over movement; grants only ever target slots inactive this cycle.
      for (int i = 0; i < 4; i++) begin
        if (r_active[i]) begin
          if (bullet_destroy[i]) begin
            r_active[i] <= 1'b0;
          end else if (tick) begin
            if (w_mv_ok[i]) begin
              r_x[i] <= w_nx[i][7:0];
              r_y[i] <= w_ny[i][7:0];
            end else begin
              r_active[i] <= 1'b0;
            end
          end
        end
      end
      if (w_g1) begin
        r_active[w_s1] <= 1'b1;
        r_x[w_s1]      <= w_sp1[17:10];
        r_y[w_s1]      <= w_sp1[7:0];
        r_owner[w_s1]  <= 1'b0;
        r_dir[w_s1]    <= p1_dir;
      end
      if (w_g2) begin
        r_active[w_s2] <= 1'b1;
        r_x[w_s2]      <= w_sp2[17:10];
        r_y[w_s2]      <= w_sp2[7:0];
        r_owner[w_s2]  <= 1'b1;
        r_dir[w_s2]    <= p2_dir;
      end
    end
  end

  assign bullet_active = r_active;
  assign bullet_owner  = r_owner;
  assign bullet_x0     = r_x[0];
  assign bullet_x1     = r_x[1];
  assign bullet_x2     = r_x[2];
  assign bullet_x3     = r_x[3];
  assign bullet_y0     = r_y[0];
  assign bullet_y1     = r_y[1];
  assign bullet_y2     = r_y[2];
  assign bullet_y3     = r_y[3];
  assign p1_fire_ack   = r_ack1;
  assign p2_fire_ack   = r_ack2;

endmodule
